s_block_sram_writer: RTL and testbench



---
 rtl/s_block_sram_writer_pkg.sv | 18 +
 rtl/s_block_sram_writer_if.sv | 30 +++
 rtl/s_block_sram_writer_clip8.sv | 25 ++
 rtl/s_block_sram_writer.sv | 131 +++++++++++++
 tb/tb_s_block_sram_writer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/s_block_sram_writer_pkg.sv
// Shared types and constants for the S block SRAM writer.
package s_block_sram_writer_pkg;

  localparam int S_BASE_DEF    = 64;   // dpram address of S[0][0]
  localparam int ROW_WORDS_DEF = 160;  // SRAM words per image row
  localparam int SHIFT_DEF     = 16;   // fixed-point fraction bits dropped before clipping
  localparam int DP_AW         = 7;    // S dpram address width
  localparam int SR_AW         = 18;   // external SRAM word address width

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_t;

endpackage

// File: rtl/s_block_sram_writer_if.sv
// S dpram read ports, SRAM write bus and block handshake bundled together.
interface s_block_sram_writer_if;
  import s_block_sram_writer_pkg::*;

  logic [DP_AW-1:0] Address_S_a;
  logic [31:0]      Data_out_S_a;
  logic [DP_AW-1:0] Address_S_b;
  logic [31:0]      Data_out_S_b;
  logic [SR_AW-1:0] dest_base;
  logic [4:0]       block_row;
  logic [5:0]       block_col;
  logic [SR_AW-1:0] SRAM_address;
  logic [15:0]      SRAM_write_data;
  logic             SRAM_we_n;
  logic             start;
  logic             finish;

  // the writer block
  modport master (
    output Address_S_a, Address_S_b, SRAM_address, SRAM_write_data, SRAM_we_n, finish,
    input  Data_out_S_a, Data_out_S_b, dest_base, block_row, block_col, start
  );

  // the dpram / SRAM / sequencer side
  modport slave (
    input  Address_S_a, Address_S_b, SRAM_address, SRAM_write_data, SRAM_we_n, finish,
    output Data_out_S_a, Data_out_S_b, dest_base, block_row, block_col, start
  );

endinterface

// File: rtl/s_block_sram_writer_clip8.sv
// Scales one signed S value down by SHIFT and saturates it to an 8-bit pixel.
module s_clip8
  import s_block_sram_writer_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic [31:0] val_i,
  output logic [7:0]  pix_o
);

  logic signed [31:0] shifted;

  assign shifted = $signed(val_i) >>> SHIFT;

  // saturate on the shifted value so fractions just below zero still clip to 0
  always_comb begin
    pix_o = shifted[7:0];
    if (shifted < 0) begin
      pix_o = 8'd0;
    end else if (shifted > 32'sd255) begin
      pix_o = 8'hFF;
    end
  end

endmodule

// File: rtl/s_block_sram_writer.sv
// Drains one 8x8 S block from the S dpram, clips it to pixels and writes
// packed pixel pairs into the current image plane in SRAM.
//
// state    | meaning
// S_IDLE   | waiting for start, outputs quiet
// S_READ   | issuing dpram read pairs 1..31, writes start trailing by two
// S_DRAIN1 | no more reads, read pipeline still holds two pairs
// S_DRAIN2 | last write goes out, then finish is raised
// S_DONE   | finish pulse cycle, back to idle
module s_block_sram_writer
  import s_block_sram_writer_pkg::*;
#(
  parameter int S_BASE    = S_BASE_DEF,
  parameter int ROW_WORDS = ROW_WORDS_DEF,
  parameter int SHIFT     = SHIFT_DEF
) (
  input  logic                  Clock_50,
  input  logic                  Resetn,
  s_block_sram_writer_if.master bus
);

  localparam logic [DP_AW-1:0] S_BASE_A = DP_AW'(S_BASE);
  localparam logic [SR_AW-1:0] ROW_STEP = SR_AW'(ROW_WORDS);
  localparam logic [SR_AW-1:0] BLK_ROW_STEP = SR_AW'(8 * ROW_WORDS);

  state_t           state_q;
  logic [4:0]       pair_cnt_q;
  logic             iss_q;       // a read pair was issued on the last edge
  logic             dp_q;        // dpram data for a pair is valid this cycle
  logic [1:0]       col_q;       // word column within the block row
  logic [SR_AW-1:0] row_addr_q;  // SRAM address of the current block row
  logic [DP_AW-1:0] addr_a_q;
  logic [DP_AW-1:0] addr_b_q;
  logic [SR_AW-1:0] sram_addr_q;
  logic [15:0]      sram_data_q;
  logic             we_n_q;
  logic             finish_q;

  logic [4:0]       pair_d;
  logic [SR_AW-1:0] base_d;
  logic [7:0]       pix_a;
  logic [7:0]       pix_b;

  assign pair_d = pair_cnt_q + 5'd1;
  assign base_d = bus.dest_base
                + SR_AW'(bus.block_row) * BLK_ROW_STEP
                + SR_AW'({bus.block_col, 2'b00});

  s_clip8 #(.SHIFT(SHIFT)) u_clip_a (.val_i(bus.Data_out_S_a), .pix_o(pix_a));
  s_clip8 #(.SHIFT(SHIFT)) u_clip_b (.val_i(bus.Data_out_S_b), .pix_o(pix_b));

  // sequencing FSM, read issue, and the two-cycle-delayed SRAM write stage
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      pair_cnt_q  <= '0;
      iss_q       <= 1'b0;
      dp_q        <= 1'b0;
      col_q       <= '0;
      row_addr_q  <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      we_n_q      <= 1'b1;
      finish_q    <= 1'b0;
    end else begin
      we_n_q   <= 1'b1;
      finish_q <= 1'b0;
      dp_q     <= iss_q;

      // consume the pair whose dpram data is valid now
      if (dp_q) begin
        sram_data_q <= {pix_a, pix_b};
        sram_addr_q <= row_addr_q + SR_AW'(col_q);
        we_n_q      <= 1'b0;
        col_q       <= col_q + 2'd1;
        if (col_q == 2'd3) begin
          row_addr_q <= row_addr_q + ROW_STEP;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            row_addr_q <= base_d;
            col_q      <= '0;
            addr_a_q   <= S_BASE_A;
            addr_b_q   <= S_BASE_A + DP_AW'(1);
            pair_cnt_q <= '0;
            iss_q      <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          pair_cnt_q <= pair_d;
          addr_a_q   <= S_BASE_A + {1'b0, pair_d, 1'b0};
          addr_b_q   <= S_BASE_A + {1'b0, pair_d, 1'b1};
          if (pair_cnt_q == 5'd30) begin
            state_q <= S_DRAIN1;
          end
        end
        S_DRAIN1: begin
          iss_q   <= 1'b0;
          state_q <= S_DRAIN2;
        end
        S_DRAIN2: begin
          // the final write leaves while dp_q is still set; finish follows it
          if (!dp_q) begin
            finish_q <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Address_S_a     = addr_a_q;
  assign bus.Address_S_b     = addr_b_q;
  assign bus.SRAM_address    = sram_addr_q;
  assign bus.SRAM_write_data = sram_data_q;
  assign bus.SRAM_we_n       = we_n_q;
  assign bus.finish          = finish_q;

endmodule

// File: tb/tb_s_block_sram_writer.sv
// Bench for s_block_sram_writer: dpram and SRAM models, a timing model of the
// block transfer, and directed scenarios with literal expectations.
module tb_s_block_sram_writer;

  logic Clock_50;
  logic Resetn;
  s_block_sram_writer_if bus_if ();

  s_block_sram_writer dut (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .bus      (bus_if)
  );

  initial Clock_50 = 1'b0;
  always #10 Clock_50 = ~Clock_50;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // S dpram: synchronous read, address registered by the DUT one edge earlier
  logic [31:0] s_mem [0:127];
  always @(posedge Clock_50) begin
    bus_if.Data_out_S_a <= s_mem[bus_if.Address_S_a];
    bus_if.Data_out_S_b <= s_mem[bus_if.Address_S_b];
  end

  int cyc = 0;
  always @(posedge Clock_50) cyc <= cyc + 1;

  function automatic logic [7:0] model_pix(input logic [31:0] v);
    if (v[31]) return 8'd0;
    if (v >= 32'h0100_0000) return 8'hFF;
    return v[23:16];
  endfunction

  // transfer model: t counts edges since the accepted start edge
  bit          m_busy = 0;
  int          m_t = 0;
  int          e0_cyc = 0;
  int          e0_prev = 0;
  logic [17:0] exp_addr [0:31];
  logic [15:0] exp_data [0:31];

  always @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      m_busy = 0;
      m_t    = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == 35) m_busy = 0;
    end else if (bus_if.start) begin
      int base;
      m_busy  = 1;
      m_t     = 0;
      e0_prev = e0_cyc;
      e0_cyc  = cyc + 1;
      base = int'(bus_if.dest_base) + int'(bus_if.block_row) * 1280 + int'(bus_if.block_col) * 4;
      for (int p = 0; p < 32; p++) begin
        exp_addr[p] = 18'((base + (p / 4) * 160 + (p % 4)) % 262144);
        exp_data[p] = {model_pix(s_mem[64 + 2*p]), model_pix(s_mem[65 + 2*p])};
      end
    end
  end

  // captured SRAM writes
  logic [15:0] sram_img [0:262143];
  int          wr_count = 0;
  int          fin_count = 0;
  int          fin_cyc = 0;
  logic [17:0] first_addr, second_addr, last_addr;
  logic [15:0] first_data;

  // every-cycle comparison of the DUT against the transfer model
  always @(negedge Clock_50) begin
    if (Resetn) begin
      bit exp_we;
      exp_we = m_busy && m_t >= 2 && m_t <= 33;
      chk("we_n", int'(bus_if.SRAM_we_n), int'(!exp_we));
      chk("finish", int'(bus_if.finish), int'(m_busy && m_t == 34));
      if (exp_we) begin
        chk("sram_addr", int'(bus_if.SRAM_address), int'(exp_addr[m_t-2]));
        chk("sram_data", int'(bus_if.SRAM_write_data), int'(exp_data[m_t-2]));
      end
      if (!bus_if.SRAM_we_n) begin
        sram_img[bus_if.SRAM_address] = bus_if.SRAM_write_data;
        if (wr_count == 0) begin
          first_addr = bus_if.SRAM_address;
          first_data = bus_if.SRAM_write_data;
        end
        if (wr_count == 1) second_addr = bus_if.SRAM_address;
        last_addr = bus_if.SRAM_address;
        wr_count++;
      end
      if (bus_if.finish) begin
        fin_count++;
        fin_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge Clock_50);
    #1;
  endtask

  task automatic clear_counts();
    wr_count  = 0;
    fin_count = 0;
  endtask

  task automatic run_block(input logic [17:0] base, input logic [4:0] row, input logic [5:0] col);
    int n;
    clear_counts();
    bus_if.dest_base = base;
    bus_if.block_row = row;
    bus_if.block_col = col;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n = 0;
    while (fin_count == 0 && n < 60) begin
      tick();
      n++;
    end
    if (fin_count == 0) chk("finish_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 128; i++) s_mem[i] = 32'(i - 64) << 16;
  endtask

  initial begin
    int n;
    Resetn = 1'b0;
    bus_if.start = 1'b0;
    bus_if.dest_base = '0;
    bus_if.block_row = '0;
    bus_if.block_col = '0;
    for (int i = 0; i < 128; i++) s_mem[i] = '0;
    repeat (3) tick();
    chk("rst_addr_a", int'(bus_if.Address_S_a), 0);
    chk("rst_addr_b", int'(bus_if.Address_S_b), 0);
    chk("rst_sram_addr", int'(bus_if.SRAM_address), 0);
    chk("rst_sram_data", int'(bus_if.SRAM_write_data), 0);
    chk("rst_we_n", int'(bus_if.SRAM_we_n), 1);
    chk("rst_finish", int'(bus_if.finish), 0);
    Resetn = 1'b1;
    repeat (2) tick();

    // ramp block at plane origin
    load_ramp();
    run_block(18'h0, 5'd0, 6'd0);
    chk("ramp_writes", wr_count, 32);
    chk("ramp_addr161", int'(sram_img[161]), 16'h0A0B);
    chk("ramp_addr0", int'(sram_img[0]), 16'h0001);
    chk("ramp_last_addr", int'(last_addr), 7*160 + 3);
    chk("ramp_finish_edge", fin_cyc - e0_cyc, 34);

    // clipping corners
    for (int i = 0; i < 128; i++) s_mem[i] = '0;
    s_mem[64] = 32'hFFFF_0000;
    s_mem[65] = 32'd300 << 16;
    s_mem[66] = 32'h00FF_8000;
    run_block(18'h0, 5'd0, 6'd0);
    chk("clip_addr0", int'(sram_img[0]), 16'h00FF);
    chk("clip_addr1_hi", int'(sram_img[1][15:8]), 8'hFF);

    // block placement
    run_block(18'h100, 5'd2, 6'd5);
    chk("place_first", int'(first_addr), 18'hB14);
    chk("place_last", int'(last_addr), 18'hF77);

    // start held high across two blocks
    load_ramp();
    clear_counts();
    bus_if.start = 1'b1;
    n = 0;
    while (fin_count < 2 && n < 100) begin
      tick();
      n++;
    end
    if (fin_count < 2) chk("held_timeout", fin_count, 2);
    bus_if.start = 1'b0;
    repeat (5) tick();
    chk("held_writes", wr_count, 64);
    chk("held_finishes", fin_count, 2);
    chk("held_restart_gap", e0_cyc - e0_prev, 36);

    // reset after the tenth write, then a clean block
    clear_counts();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n = 0;
    while (wr_count < 10 && n < 40) begin
      tick();
      n++;
    end
    Resetn = 1'b0;
    #1;
    chk("abort_we_n", int'(bus_if.SRAM_we_n), 1);
    chk("abort_finish", int'(bus_if.finish), 0);
    repeat (3) tick();
    Resetn = 1'b1;
    repeat (2) tick();
    chk("abort_writes", wr_count, 10);
    run_block(18'h0, 5'd0, 6'd0);
    chk("post_rst_writes", wr_count, 32);
    chk("post_rst_first_addr", int'(first_addr), 0);
    chk("post_rst_first_data", int'(first_data), 16'h0001);

    // SRAM address wrap
    run_block(18'h3FFFF, 5'd0, 6'd0);
    chk("wrap_first", int'(first_addr), 18'h3FFFF);
    chk("wrap_second", int'(second_addr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
